// File: rtl/gpc_dst_accum.sv
// gpc_dst_accum: sums BEATS consecutive GPC(1,5,1) results (0..15) into one
// ACC_W-bit output word with a sticky overflow flag, using valid/ready on
// both sides.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   dst[3:0]             GPC result to accumulate (weight 1)
//   in_valid / in_ready  input handshake (in_ready is combinational)
//   out_data[ACC_W-1:0]  completed group sum
//   out_ovf              group sum exceeded 2^ACC_W-1
//   out_valid/out_ready  output handshake
//
// Build option: define GPC_ACC_SAT_EN to saturate the sum at 2^ACC_W-1 once
// it overflows; otherwise it wraps modulo 2^ACC_W. out_ovf is the same in
// both builds.
module gpc_dst_accum #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned BEATS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       dst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;

    logic               in_accept;
    logic               out_take;
    logic [ACC_W:0]     sum_full;
    logic               ovf_new;
    logic [ACC_W-1:0]   sum_v;

    assign out_valid = (state_q == S_HOLD);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // A held result only blocks input when the consumer is not taking it.
    assign in_ready  = ~out_valid | out_ready;
    assign in_accept = in_valid & in_ready;
    assign out_take  = out_valid & out_ready;

    // Running sum with carry; the extra bit is the overflow of this beat.
    always_comb begin
        sum_full = {1'b0, acc_q} + (ACC_W + 1)'(dst);
        ovf_new  = ovf_q | sum_full[ACC_W];
`ifdef GPC_ACC_SAT_EN
        sum_v    = ovf_new ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
        sum_v    = sum_full[ACC_W-1:0];
`endif
    end

    // Next-state: acc is already cleared in HOLD, so a beat accepted in the
    // same cycle as out_take naturally lands as beat 0 of the next group.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;

        if (out_take) begin
            state_d = S_ACCUM;
        end

        if (in_accept) begin
            if (cnt_q == CNT_LAST) begin
                out_data_d = sum_v;
                out_ovf_d  = ovf_new;
                acc_d      = '0;
                ovf_d      = 1'b0;
                cnt_d      = '0;
                state_d    = S_HOLD;
            end else begin
                acc_d = sum_v;
                ovf_d = ovf_new;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ACCUM;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_gpc_dst_accum.sv
// Directed bench for gpc_dst_accum. Four instances share the input stimulus:
// A (ACC_W=16,BEATS=4), S (ACC_W=5,BEATS=4), B2 (BEATS=2), B1 (BEATS=1).
// Each scenario resets all instances and checks the relevant one(s).
module tb_gpc_dst_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dst;
    logic       in_valid;
    logic       out_ready;

    logic        a_in_ready, a_out_ovf, a_out_valid;
    logic [15:0] a_out_data;
    logic        s_in_ready, s_out_ovf, s_out_valid;
    logic [4:0]  s_out_data;
    logic        b2_in_ready, b2_out_ovf, b2_out_valid;
    logic [15:0] b2_out_data;
    logic        b1_in_ready, b1_out_ovf, b1_out_valid;
    logic [15:0] b1_out_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpc_dst_accum #(.ACC_W(16), .BEATS(4)) u_a (
        .clk(clk), .rst_n(rst_n), .dst(dst), .in_valid(in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_ovf(a_out_ovf),
        .out_valid(a_out_valid), .out_ready(out_ready));

    gpc_dst_accum #(.ACC_W(5), .BEATS(4)) u_s (
        .clk(clk), .rst_n(rst_n), .dst(dst), .in_valid(in_valid),
        .in_ready(s_in_ready), .out_data(s_out_data), .out_ovf(s_out_ovf),
        .out_valid(s_out_valid), .out_ready(out_ready));

    gpc_dst_accum #(.ACC_W(16), .BEATS(2)) u_b2 (
        .clk(clk), .rst_n(rst_n), .dst(dst), .in_valid(in_valid),
        .in_ready(b2_in_ready), .out_data(b2_out_data), .out_ovf(b2_out_ovf),
        .out_valid(b2_out_valid), .out_ready(out_ready));

    gpc_dst_accum #(.ACC_W(16), .BEATS(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .dst(dst), .in_valid(in_valid),
        .in_ready(b1_in_ready), .out_data(b1_out_data), .out_ovf(b1_out_ovf),
        .out_valid(b1_out_valid), .out_ready(out_ready));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dst       = 4'd0;
        rst_n     = 1'b0;
        #7;
        rst_n     = 1'b1;
        tick();
    endtask

    task automatic beat(input logic [3:0] d);
        in_valid = 1'b1;
        dst      = d;
        tick();
    endtask

    int          m_sum, m_cnt;
    logic        m_valid;
    logic [15:0] m_data;
    logic        exp_rdy, m_acc, m_take;

    initial begin
        // Reset state, checked while reset is held
        in_valid = 1'b0; out_ready = 1'b0; dst = 4'd0; rst_n = 1'b0;
        #12;
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_out_data",  a_out_data, 0);
        chk("rst_a_out_ovf",   a_out_ovf, 0);
        chk("rst_a_in_ready",  a_in_ready, 1);
        chk("rst_b1_out_valid", b1_out_valid, 0);
        rst_n = 1'b1;
        tick();

        // Four beats of 15, back to back; S instance exercises overflow
        out_ready = 1'b1;
        beat(4'd15); beat(4'd15); beat(4'd15);
        chk("max_a_valid_before_last", a_out_valid, 0);
        beat(4'd15);
        in_valid = 1'b0;
        chk("max_a_out_valid", a_out_valid, 1);
        chk("max_a_out_data",  a_out_data, 60);
        chk("max_a_out_ovf",   a_out_ovf, 0);
        chk("ovf_s_out_valid", s_out_valid, 1);
`ifdef GPC_ACC_SAT_EN
        chk("ovf_s_out_data",  s_out_data, 31);
`else
        chk("ovf_s_out_data",  s_out_data, 28);
`endif
        chk("ovf_s_out_ovf",   s_out_ovf, 1);
        tick();
        chk("max_a_taken", a_out_valid, 0);

        // BEATS=2 backpressure: hold result, then take with a new beat 0
        do_reset();
        beat(4'd3); beat(4'd4);
        in_valid = 1'b1; dst = 4'd9; out_ready = 1'b0;
        #1;
        chk("bp_b2_in_ready", b2_in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_b2_out_valid", b2_out_valid, 1);
            chk("bp_b2_out_data",  b2_out_data, 7);
            chk("bp_b2_in_ready",  b2_in_ready, 0);
        end
        out_ready = 1'b1; dst = 4'd7;
        #1;
        chk("bp_b2_in_ready_take", b2_in_ready, 1);
        tick();
        chk("bp_b2_after_take_valid", b2_out_valid, 0);
        beat(4'd1);
        in_valid = 1'b0;
        chk("bp_b2_next_valid", b2_out_valid, 1);
        chk("bp_b2_next_data",  b2_out_data, 8);

        // BEATS=1 streaming with no bubbles
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            beat(4'(i));
            chk("b1_out_valid", b1_out_valid, 1);
            chk("b1_out_data",  b1_out_data, 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("b1_drained", b1_out_valid, 0);

        // Reset in the middle of a partial group
        do_reset();
        out_ready = 1'b1;
        beat(4'd5); beat(4'd5);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_a_out_valid", a_out_valid, 0);
        #2 rst_n = 1'b1;
        beat(4'd1); beat(4'd2);
        chk("midrst_a_no_early", a_out_valid, 0);
        beat(4'd3); beat(4'd4);
        in_valid = 1'b0;
        chk("midrst_a_out_valid", a_out_valid, 1);
        chk("midrst_a_out_data",  a_out_data, 10);
        tick();

        // Random valid/ready against a behavioural reference
        do_reset();
        m_valid = 1'b0; m_sum = 0; m_cnt = 0; m_data = '0;
        for (int i = 0; i < 1000; i++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(3, 0) != 0);
            dst       = 4'($urandom_range(15, 0));
            #1;
            exp_rdy = !m_valid || out_ready;
            chk("rnd_in_ready", a_in_ready, exp_rdy);
            m_acc  = in_valid && exp_rdy;
            m_take = m_valid && out_ready;
            if (m_take) m_valid = 1'b0;
            if (m_acc) begin
                m_sum = m_sum + int'(dst);
                m_cnt = m_cnt + 1;
                if (m_cnt == 4) begin
                    m_data  = 16'(m_sum);
                    m_valid = 1'b1;
                    m_sum   = 0;
                    m_cnt   = 0;
                end
            end
            tick();
            chk("rnd_out_valid", a_out_valid, m_valid);
            if (m_valid) begin
                chk("rnd_out_data", a_out_data, m_data);
                chk("rnd_out_ovf",  a_out_ovf, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
